uart_rx_os: RTL and testbench

//   Oversampling UART receiver. Replaces the single-sample shift receiver.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 38 +++
 rtl/uart_rx_os.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Types and constants shared by the UART receive and transmit blocks.
//   rx_state_t  : receiver FSM states, in frame order.
//   PARITY_EVEN : value for a PARITY_ODD parameter selecting even parity.
//   PARITY_ODD  : value for a PARITY_ODD parameter selecting odd parity.
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// ----------------------------------------------------------------------------
// uart_sync2
//   Two-flop synchroniser for a single asynchronous level.
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     i_d    in   asynchronous input
//     o_q    out  synchronised output (two clocks of latency)
//   RST_VAL sets the value both flops take in reset, so a line that idles
//   high does not look like a start edge when reset is released.
// ----------------------------------------------------------------------------
module uart_sync2 #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_os.sv
// ----------------------------------------------------------------------------
// uart_rx_os
//   Oversampling UART receiver. Samples each bit once, CLK_DIV/2 clocks after
//   its nominal leading edge, and hands whole frames to a valid/ready holding
//   register together with per-frame parity and framing flags.
//   Ports:
//     clk         in   system clock
//     rst_n       in   asynchronous active-low reset
//     en          in   receiver enable; low abandons the frame in progress
//     rx          in   asynchronous serial line, idles high
//     data        out  received payload, meaningful while valid=1
//     valid       out  holding register is full
//     ready       in   consumer accepts the held frame when valid & ready
//     parity_err  out  parity mismatch for the held frame
//     frame_err   out  stop bit was sampled low for the held frame
//     overrun     out  a frame was dropped because the register was full;
//                      cleared by the next handshake
// ----------------------------------------------------------------------------
module uart_rx_os #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = uart_pkg::PARITY_EVEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  // Named imports: a wildcard import would clash with the PARITY_ODD parameter.
  import uart_pkg::rx_state_t;
  import uart_pkg::IDLE;
  import uart_pkg::START;
  import uart_pkg::DATA;
  import uart_pkg::PARITY;
  import uart_pkg::STOP;

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  // The IDLE cycle that sees the start bit is counted as the first cycle of
  // the half-bit wait, so START is entered with the counter already at 1.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_take;

  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bits;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr_pend;
  logic                 r_ferr_pend;
  logic                 r_done;
  logic                 r_brk;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_ovr;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // Frame recovery. r_done pulses for one cycle after the stop sample; the
  // holding register picks the frame up on that following edge.
  // NOTE: every control and datapath flop is reset here; there is no memory
  // array, so nothing is left to power up undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bits      <= '0;
      r_shift     <= '0;
      r_perr_pend <= 1'b0;
      r_ferr_pend <= 1'b0;
      r_done      <= 1'b0;
      r_brk       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_bits  <= '0;
        r_brk   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt  <= '0;
            r_bits <= '0;
            r_brk  <= 1'b0;
            if (!w_rx_s) begin
              r_state     <= START;
              r_cnt       <= CNT_W'(1);
              r_perr_pend <= 1'b0;
            end
          end
          START: begin
            if (r_cnt == CNT_HALF) begin
              r_cnt   <= '0;
              // A line that is high again at mid start bit was only a glitch.
              r_state <= w_rx_s ? IDLE : DATA;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DATA: begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              r_bits  <= r_bits + 1'b1;
              if (r_bits == BIT_LAST) begin
                r_state <= PARITY_EN ? PARITY : STOP;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (r_cnt == CNT_LAST) begin
              r_cnt       <= '0;
              r_perr_pend <= (^r_shift) ^ w_rx_s ^ PARITY_ODD;
              r_state     <= STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          STOP: begin
            if (r_brk) begin
              // Break: hold off until the line idles, so a long low level is
              // not mistaken for a string of start bits.
              if (w_rx_s) begin
                r_brk   <= 1'b0;
                r_state <= IDLE;
              end
            end else if (r_cnt == CNT_LAST) begin
              r_cnt       <= '0;
              r_done      <= 1'b1;
              r_ferr_pend <= ~w_rx_s;
              if (w_rx_s) begin
                r_state <= IDLE;
              end else begin
                r_brk <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign w_take = r_valid & ready;

  // Holding register. A frame that completes while the register is full and
  // not being drained is dropped; the held frame is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_take) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
      if (r_done) begin
        if (!r_valid || ready) begin
          r_data  <= r_shift;
          r_perr  <= r_perr_pend;
          r_ferr  <= r_ferr_pend;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_os.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_os
//   Directed bench for uart_rx_os. Two instances: dut (no parity) and dut_p
//   (even parity), each on its own serial line. Bits last 16 clocks. Frames
//   are driven starting just after a clock edge E; the line reaches rx_s two
//   edges later, so t0 = E + 2 and a spec latency of t0+N is E+N+2 here.
// ----------------------------------------------------------------------------
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       rst_n, en, rx, rx_p, ready, ready_p;
  logic [7:0] data, data_p;
  logic       valid, valid_p, perr, perr_p, ferr, ferr_p, ovr, ovr_p;

  int cyc       = 0;
  int valid_cnt = 0;
  int checks    = 0;
  int failures  = 0;

  uart_rx_os #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rx(rx),
    .data(data), .valid(valid), .ready(ready),
    .parity_err(perr), .frame_err(ferr), .overrun(ovr)
  );

  uart_rx_os #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .rst_n(rst_n), .en(en), .rx(rx_p),
    .data(data_p), .valid(valid_p), .ready(ready_p),
    .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Number of cycles dut has shown valid=1.
  always @(negedge clk) if (valid === 1'b1) valid_cnt = valid_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame, LSB first, 16 clocks per bit. Leaves the line at the
  // stop-bit level.
  task automatic send_frame(input bit to_p, input logic [7:0] d,
                            input bit has_par, input bit par, input bit stop);
    logic [10:0] v;
    int          n;
    if (has_par) begin
      v = {stop, par, d, 1'b0};
      n = 11;
    end else begin
      v = {1'b0, stop, d, 1'b0};
      n = 10;
    end
    for (int i = 0; i < n; i++) begin
      if (to_p) rx_p = v[i];
      else      rx   = v[i];
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  // Wait for valid to rise and report the edge count since 'start'.
  task automatic wait_valid(input bit from_p, input int start, input int budget,
                            output int lat, output logic [7:0] d,
                            output logic pe, output logic fe);
    lat = -1;
    d   = 8'h00;
    pe  = 1'b0;
    fe  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((from_p ? valid_p : valid) === 1'b1) begin
        lat = cyc - start;
        d   = from_p ? data_p : data;
        pe  = from_p ? perr_p : perr;
        fe  = from_p ? ferr_p : ferr;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (perr !== 1'b0 || ferr !== 1'b0) begin failures++; $display("FAIL reset_errs got=%b%b exp=00", perr, ferr); end
    checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", ovr); end
    checks++; if (valid_p !== 1'b0 || data_p !== 8'h00) begin failures++; $display("FAIL reset_dut_p got=%b/%h exp=0/00", valid_p, data_p); end
  endtask

  task automatic test_basic();
    int lat, v0, start; logic [7:0] d; logic pe, fe;
    v0 = valid_cnt; start = cyc;
    fork
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      wait_valid(1'b0, start, 200, lat, d, pe, fe);
    join
    step();
    checks++; if (lat !== 155) begin failures++; $display("FAIL basic_latency got=%0d exp=155", lat); end
    checks++; if (d !== 8'h55) begin failures++; $display("FAIL basic_data got=%h exp=55", d); end
    checks++; if (pe !== 1'b0 || fe !== 1'b0) begin failures++; $display("FAIL basic_errs got=%b%b exp=00", pe, fe); end
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL basic_valid_cycles got=%0d exp=1", valid_cnt - v0); end
  endtask

  task automatic test_parity();
    int lat, start; logic [7:0] d; logic pe, fe;
    // 0xA3 has four ones: even parity bit is 0.
    start = cyc;
    fork
      send_frame(1'b1, 8'hA3, 1'b1, 1'b0, 1'b1);
      wait_valid(1'b1, start, 220, lat, d, pe, fe);
    join
    step();
    checks++; if (lat !== 171) begin failures++; $display("FAIL parity_latency got=%0d exp=171", lat); end
    checks++; if (d !== 8'hA3) begin failures++; $display("FAIL parity_data got=%h exp=a3", d); end
    checks++; if (pe !== 1'b0 || fe !== 1'b0) begin failures++; $display("FAIL parity_good_errs got=%b%b exp=00", pe, fe); end
    start = cyc;
    fork
      send_frame(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1);
      wait_valid(1'b1, start, 220, lat, d, pe, fe);
    join
    step();
    checks++; if (d !== 8'hA3) begin failures++; $display("FAIL parity_bad_data got=%h exp=a3", d); end
    checks++; if (pe !== 1'b1 || fe !== 1'b0) begin failures++; $display("FAIL parity_bad_errs got=%b%b exp=10", pe, fe); end
  endtask

  task automatic test_break();
    int lat, v0, start; logic [7:0] d; logic pe, fe;
    v0 = valid_cnt; start = cyc;
    fork
      begin
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        rx = 1'b1;
      end
      wait_valid(1'b0, start, 250, lat, d, pe, fe);
    join
    step();
    checks++; if (lat !== 155) begin failures++; $display("FAIL break_latency got=%0d exp=155", lat); end
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL break_data got=%h exp=3c", d); end
    checks++; if (fe !== 1'b1 || pe !== 1'b0) begin failures++; $display("FAIL break_errs got=%b%b exp=01", pe, fe); end
    repeat (20) step();
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL break_no_refire got=%0d exp=1", valid_cnt - v0); end
    start = cyc;
    fork
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      wait_valid(1'b0, start, 200, lat, d, pe, fe);
    join
    step();
    checks++; if (d !== 8'h5A || fe !== 1'b0) begin failures++; $display("FAIL break_recover got=%h/%b exp=5a/0", d, fe); end
    checks++; if (valid_cnt - v0 !== 2) begin failures++; $display("FAIL break_frame_count got=%0d exp=2", valid_cnt - v0); end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = valid_cnt;
    rx = 1'b0;
    repeat (5) step();
    rx = 1'b1;
    // Glitch driven after edge E, so t0 = E+2; six more edges reach t0+9.
    repeat (6) step();
    checks++; if (dut.r_state !== uart_pkg::IDLE) begin failures++; $display("FAIL glitch_state got=%0d exp=%0d", dut.r_state, uart_pkg::IDLE); end
    repeat (170) step();
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL glitch_no_valid got=%0d exp=0", valid_cnt - v0); end
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    checks++; if (valid !== 1'b1 || data !== 8'h11 || ovr !== 1'b0) begin failures++; $display("FAIL ovr_first got=%b/%h/%b exp=1/11/0", valid, data, ovr); end
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (4) step();
    checks++; if (data !== 8'h11) begin failures++; $display("FAIL ovr_data_kept got=%h exp=11", data); end
    checks++; if (valid !== 1'b1 || ovr !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b/%b exp=1/1", valid, ovr); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (valid !== 1'b0 || ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b/%b exp=0/0", valid, ovr); end
    ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_enable();
    int lat, v0, start; logic [7:0] d; logic pe, fe;
    v0 = valid_cnt;
    fork
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
      begin
        repeat (72) @(posedge clk);  // middle of data bit 3
        #1;
        en = 1'b0;
      end
    join
    repeat (4) step();
    en = 1'b1;
    repeat (4) step();
    start = cyc;
    fork
      send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
      wait_valid(1'b0, start, 200, lat, d, pe, fe);
    join
    step();
    checks++; if (lat !== 155 || d !== 8'h7E) begin failures++; $display("FAIL enable_frame got=%0d/%h exp=155/7e", lat, d); end
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL enable_abort got=%0d exp=1", valid_cnt - v0); end
  endtask

  task automatic test_async_reset();
    int lat, start; logic [7:0] d; logic pe, fe;
    ready = 1'b0;
    send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h44, 1'b0, 1'b0, 1'b1);
    repeat (4) step();
    checks++; if (valid !== 1'b1 || data !== 8'h33 || ovr !== 1'b1) begin failures++; $display("FAIL rst_pre got=%b/%h/%b exp=1/33/1", valid, data, ovr); end
    rx = 1'b0;
    repeat (16) step();
    rx = 1'b1;
    repeat (16) step();
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (data !== 8'h00 || valid !== 1'b0) begin failures++; $display("FAIL rst_async_out got=%h/%b exp=00/0", data, valid); end
    checks++; if (ovr !== 1'b0 || perr !== 1'b0 || ferr !== 1'b0) begin failures++; $display("FAIL rst_async_flags got=%b%b%b exp=000", ovr, perr, ferr); end
    rx = 1'b1;
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (4) step();
    start = cyc;
    fork
      send_frame(1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
      wait_valid(1'b0, start, 200, lat, d, pe, fe);
    join
    step();
    checks++; if (lat !== 155 || d !== 8'h66) begin failures++; $display("FAIL rst_resume got=%0d/%h exp=155/66", lat, d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    rx      = 1'b1;
    rx_p    = 1'b1;
    ready   = 1'b1;
    ready_p = 1'b1;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    repeat (4) step();
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_overrun();
    test_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
